// File: rtl/sim_completion_ctrl_if.sv
// Bundles the masked GPIO sample and the completion status flags of sim_completion_ctrl.
// master = Verilator top level side, slave = the controller.
interface sim_completion_ctrl_if;
    logic [31:0] gpio_i;
    logic        busy_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_o;
    logic        finish_req_o;
    logic        done_o;
    logic [31:0] verdict_cycle_o;

    modport master (
        output gpio_i,
        input  busy_o, pass_o, fail_o, timeout_o, finish_req_o, done_o, verdict_cycle_o
    );

    modport slave (
        input  gpio_i,
        output busy_o, pass_o, fail_o, timeout_o, finish_req_o, done_o, verdict_cycle_o
    );
endinterface

// File: rtl/sim_completion_ctrl.sv
// End-of-test controller: qualifies software pass/fail GPIO signatures, applies an
// inactivity watchdog, then drains a fixed number of cycles before one finish request.
module sim_completion_ctrl #(
    parameter logic [31:0] PassMagic     = 32'hDEADBEEF,
    parameter logic [31:0] FailMagic     = 32'hBAADF00D,
    parameter int unsigned StableCycles  = 4,
    parameter int unsigned DrainCycles   = 7,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sim_completion_ctrl_if.slave ctrl
);

    localparam int unsigned StabW  = $clog2(StableCycles + 1);
    localparam int unsigned DrainW = $clog2(DrainCycles + 1);
    localparam logic [StabW-1:0]  StableTarget = StabW'(StableCycles);
    localparam logic [DrainW-1:0] DrainTarget  = DrainW'(DrainCycles);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_QUALIFY,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic {
        CAND_PASS,
        CAND_FAIL
    } cand_e;

    state_e             state_q, state_d;
    cand_e              cand_q, cand_d;
    logic [StabW-1:0]   stab_q, stab_d;
    logic [DrainW-1:0]  drain_q, drain_d;
    logic [31:0]        idle_q, idle_d;
    logic [31:0]        cycle_q, cycle_d;
    logic [31:0]        prev_q;
    logic [31:0]        verdict_cycle_q, verdict_cycle_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic               finish_q, finish_d;

    logic               is_pass;
    logic               is_fail;
    logic               cand_match;
    logic               other_match;
    logic               magic_verdict;
    logic               verdict_is_fail;
    logic               timeout_hit;

    assign is_pass     = (ctrl.gpio_i == PassMagic);
    assign is_fail     = (ctrl.gpio_i == FailMagic);
    assign cand_match  = (cand_q == CAND_PASS) ? is_pass : is_fail;
    assign other_match = (cand_q == CAND_PASS) ? is_fail : is_pass;

    always_comb begin
        state_d         = state_q;
        cand_d          = cand_q;
        stab_d          = stab_q;
        drain_d         = drain_q;
        idle_d          = idle_q;
        cycle_d         = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
        verdict_cycle_d = verdict_cycle_q;
        pass_d          = pass_q;
        fail_d          = fail_q;
        timeout_d       = timeout_q;
        finish_d        = 1'b0;
        magic_verdict   = 1'b0;
        verdict_is_fail = 1'b0;
        timeout_hit     = 1'b0;

        unique case (state_q)
            ST_RUN, ST_QUALIFY: begin
                if (ctrl.gpio_i != prev_q) begin
                    idle_d = 32'd0;
                end else if (idle_q != 32'hFFFF_FFFF) begin
                    idle_d = idle_q + 32'd1;
                end
                timeout_hit = (TimeoutCycles != 0) && (idle_d == TimeoutCycles);

                if (state_q == ST_RUN) begin
                    if (is_pass || is_fail) begin
                        cand_d = is_fail ? CAND_FAIL : CAND_PASS;
                        stab_d = StabW'(1);
                        if (StableCycles == 1) begin
                            magic_verdict   = 1'b1;
                            verdict_is_fail = is_fail;
                        end else begin
                            state_d = ST_QUALIFY;
                        end
                    end
                end else if (cand_match) begin
                    stab_d = stab_q + 1'b1;
                    if (stab_d == StableTarget) begin
                        magic_verdict   = 1'b1;
                        verdict_is_fail = (cand_q == CAND_FAIL);
                    end
                end else if (other_match) begin
                    // The other signature restarts qualification rather than deciding anything
                    cand_d = (cand_q == CAND_PASS) ? CAND_FAIL : CAND_PASS;
                    stab_d = StabW'(1);
                end else begin
                    state_d = ST_RUN;
                    stab_d  = '0;
                end

                if (magic_verdict || timeout_hit) begin
                    pass_d          = magic_verdict && !verdict_is_fail;
                    fail_d          = magic_verdict && verdict_is_fail;
                    timeout_d       = !magic_verdict;
                    verdict_cycle_d = cycle_q;
                    drain_d         = '0;
                    state_d         = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_d == DrainTarget) begin
                    finish_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_RUN;
            cand_q          <= CAND_PASS;
            stab_q          <= '0;
            drain_q         <= '0;
            idle_q          <= 32'd0;
            cycle_q         <= 32'd0;
            prev_q          <= 32'd0;
            verdict_cycle_q <= 32'd0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            timeout_q       <= 1'b0;
            finish_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cand_q          <= cand_d;
            stab_q          <= stab_d;
            drain_q         <= drain_d;
            idle_q          <= idle_d;
            cycle_q         <= cycle_d;
            prev_q          <= ctrl.gpio_i;
            verdict_cycle_q <= verdict_cycle_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            timeout_q       <= timeout_d;
            finish_q        <= finish_d;
        end
    end

    assign ctrl.busy_o          = (state_q == ST_RUN) || (state_q == ST_QUALIFY);
    assign ctrl.done_o          = (state_q == ST_DONE);
    assign ctrl.pass_o          = pass_q;
    assign ctrl.fail_o          = fail_q;
    assign ctrl.timeout_o       = timeout_q;
    assign ctrl.finish_req_o    = finish_q;
    assign ctrl.verdict_cycle_o = verdict_cycle_q;

endmodule

// File: tb/tb_sim_completion_ctrl.sv
// Bench for sim_completion_ctrl: three parameterisations share one directed GPIO stream and
// are checked every cycle against a run-length model, plus hand-computed literal pins.
module tb_sim_completion_ctrl;

    localparam logic [31:0] PASS_W = 32'hDEADBEEF;
    localparam logic [31:0] FAIL_W = 32'hBAADF00D;

    localparam int SIG_BUSY   = 0;
    localparam int SIG_PASS   = 1;
    localparam int SIG_FAIL   = 2;
    localparam int SIG_TMO    = 3;
    localparam int SIG_FINISH = 4;
    localparam int SIG_DONE   = 5;
    localparam int SIG_VCYC   = 6;

    typedef struct {
        string       name;
        int          inst;
        int          sig;
        logic [31:0] exp;
    } lit_t;

    logic        clk_sys;
    logic        rst_sys;
    logic [31:0] gpio;

    logic        cap_valid;
    logic        cap_rst;
    logic [31:0] cap_gpio;

    int total;
    int bad;
    lit_t lit_q[$];

    // Instance parameters: A defaults, B with watchdog, C minimal stable/drain
    int stable_p[3]  = '{4, 4, 1};
    int drain_p[3]   = '{7, 7, 1};
    int timeout_p[3] = '{0, 20, 0};

    int          m_edges[3];
    int          m_run[3];
    int          m_idle[3];
    int          m_vedge[3];
    int          m_kind[3];
    logic [31:0] m_prev[3];

    string sig_name[7] = '{"busy", "pass", "fail", "timeout", "finish", "done", "verdict_cycle"};

    sim_completion_ctrl_if bus_a ();
    sim_completion_ctrl_if bus_b ();
    sim_completion_ctrl_if bus_c ();

    assign bus_a.gpio_i = gpio;
    assign bus_b.gpio_i = gpio;
    assign bus_c.gpio_i = gpio;

    sim_completion_ctrl dut_a (
        .clk_i (clk_sys),
        .rst_i (rst_sys),
        .ctrl  (bus_a.slave)
    );

    sim_completion_ctrl #(
        .TimeoutCycles (20)
    ) dut_b (
        .clk_i (clk_sys),
        .rst_i (rst_sys),
        .ctrl  (bus_b.slave)
    );

    sim_completion_ctrl #(
        .StableCycles (1),
        .DrainCycles  (1)
    ) dut_c (
        .clk_i (clk_sys),
        .rst_i (rst_sys),
        .ctrl  (bus_c.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial cap_valid = 1'b0;
    always @(posedge clk_sys) begin
        cap_valid <= 1'b1;
        cap_rst   <= rst_sys;
        cap_gpio  <= gpio;
    end

    function automatic logic [31:0] read_out(int inst, int sig);
        logic [31:0] v [7];
        case (inst)
            0: v = '{32'(bus_a.busy_o), 32'(bus_a.pass_o), 32'(bus_a.fail_o), 32'(bus_a.timeout_o),
                     32'(bus_a.finish_req_o), 32'(bus_a.done_o), bus_a.verdict_cycle_o};
            1: v = '{32'(bus_b.busy_o), 32'(bus_b.pass_o), 32'(bus_b.fail_o), 32'(bus_b.timeout_o),
                     32'(bus_b.finish_req_o), 32'(bus_b.done_o), bus_b.verdict_cycle_o};
            default: v = '{32'(bus_c.busy_o), 32'(bus_c.pass_o), 32'(bus_c.fail_o), 32'(bus_c.timeout_o),
                     32'(bus_c.finish_req_o), 32'(bus_c.done_o), bus_c.verdict_cycle_o};
        endcase
        return v[sig];
    endfunction

    // A verdict is due once a magic word has been seen on S consecutive edges, or once the
    // GPIO word has sat unchanged for T consecutive edges; everything else follows the verdict edge.
    function automatic logic [31:0] model_out(int i, int sig);
        logic [31:0] r;
        int          fin_edge;
        fin_edge = m_vedge[i] + drain_p[i];
        case (sig)
            SIG_BUSY:   r = 32'(m_kind[i] == 0);
            SIG_PASS:   r = 32'(m_kind[i] == 1);
            SIG_FAIL:   r = 32'(m_kind[i] == 2);
            SIG_TMO:    r = 32'(m_kind[i] == 3);
            SIG_FINISH: r = 32'((m_kind[i] != 0) && (m_edges[i] == fin_edge));
            SIG_DONE:   r = 32'((m_kind[i] != 0) && (m_edges[i] >= fin_edge));
            default:    r = (m_kind[i] != 0) ? 32'(m_vedge[i] - 1) : 32'd0;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] w);
        logic is_magic;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_edges[i] = 0;
                m_run[i]   = 0;
                m_idle[i]  = 0;
                m_vedge[i] = 0;
                m_kind[i]  = 0;
                m_prev[i]  = 32'd0;
            end else begin
                m_edges[i] = m_edges[i] + 1;
                if (m_kind[i] == 0) begin
                    is_magic = (w == PASS_W) || (w == FAIL_W);
                    if (is_magic && m_run[i] > 0 && w == m_prev[i]) m_run[i] = m_run[i] + 1;
                    else if (is_magic)                              m_run[i] = 1;
                    else                                            m_run[i] = 0;
                    m_idle[i] = (w == m_prev[i]) ? m_idle[i] + 1 : 0;
                    m_prev[i] = w;
                    if (m_run[i] >= stable_p[i]) begin
                        m_kind[i]  = (w == PASS_W) ? 1 : 2;
                        m_vedge[i] = m_edges[i];
                    end else if (timeout_p[i] > 0 && m_idle[i] >= timeout_p[i]) begin
                        m_kind[i]  = 3;
                        m_vedge[i] = m_edges[i];
                    end
                end
            end
        end
    endtask

    // Single compare process: model check every cycle, then any literal pins queued for this cycle
    always @(negedge clk_sys) begin
        lit_t        e;
        logic [31:0] act;
        logic [31:0] exp;
        #1;
        if (cap_valid) begin
            model_step(cap_rst, cap_gpio);
            for (int i = 0; i < 3; i++) begin
                for (int s = 0; s < 7; s++) begin
                    act   = read_out(i, s);
                    exp   = model_out(i, s);
                    total = total + 1;
                    if (act !== exp) begin
                        bad = bad + 1;
                        $display("[TB] FAIL model inst%0d %s at %0t: got %0h want %0h",
                                 i, sig_name[s], $time, act, exp);
                    end
                end
            end
            while (lit_q.size() > 0) begin
                e     = lit_q.pop_front();
                act   = read_out(e.inst, e.sig);
                total = total + 1;
                if (act !== e.exp) begin
                    bad = bad + 1;
                    $display("[TB] FAIL %s inst%0d %s: got %0h want %0h",
                             e.name, e.inst, sig_name[e.sig], act, e.exp);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] word, input int n);
        gpio = word;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic applyReset();
        rst_sys = 1'b1;
        @(negedge clk_sys);
        rst_sys = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int inst, input int sig, input logic [31:0] exp);
        lit_t e;
        e.name = name;
        e.inst = inst;
        e.sig  = sig;
        e.exp  = exp;
        lit_q.push_back(e);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_sys = 1'b1;
        gpio    = 32'd0;
        repeat (2) @(negedge clk_sys);
        checkOutput("reset_busy", 0, SIG_BUSY, 32'd1);
        checkOutput("reset_vcyc", 0, SIG_VCYC, 32'd0);
        rst_sys = 1'b0;

        // Pass after idle zeros; C decides on the first match and finishes one edge later
        applyStimulus(32'd0, 10);
        applyStimulus(PASS_W, 1);
        checkOutput("c_first_match", 2, SIG_PASS, 32'd1);
        checkOutput("c_vcyc", 2, SIG_VCYC, 32'd10);
        checkOutput("c_no_finish_yet", 2, SIG_FINISH, 32'd0);
        applyStimulus(PASS_W, 1);
        checkOutput("c_finish", 2, SIG_FINISH, 32'd1);
        checkOutput("c_done", 2, SIG_DONE, 32'd1);
        applyStimulus(PASS_W, 1);
        checkOutput("a_three_matches", 0, SIG_PASS, 32'd0);
        checkOutput("c_finish_once", 2, SIG_FINISH, 32'd0);
        applyStimulus(PASS_W, 1);
        checkOutput("a_pass", 0, SIG_PASS, 32'd1);
        checkOutput("a_vcyc", 0, SIG_VCYC, 32'd13);
        checkOutput("a_busy_fall", 0, SIG_BUSY, 32'd0);
        applyStimulus(PASS_W, 6);
        checkOutput("a_drain_no_finish", 0, SIG_FINISH, 32'd0);
        applyStimulus(PASS_W, 1);
        checkOutput("a_finish", 0, SIG_FINISH, 32'd1);
        checkOutput("a_done", 0, SIG_DONE, 32'd1);
        applyStimulus(FAIL_W, 5);
        checkOutput("done_ignores_fail", 0, SIG_FAIL, 32'd0);
        checkOutput("done_holds_pass", 0, SIG_PASS, 32'd1);
        checkOutput("done_no_refinish", 0, SIG_FINISH, 32'd0);

        // Glitch restarts qualification
        applyReset();
        applyStimulus(PASS_W, 3);
        applyStimulus(32'd0, 1);
        applyStimulus(PASS_W, 3);
        checkOutput("glitch_no_pass", 0, SIG_PASS, 32'd0);
        applyStimulus(PASS_W, 1);
        checkOutput("glitch_pass", 0, SIG_PASS, 32'd1);
        checkOutput("glitch_vcyc", 0, SIG_VCYC, 32'd7);

        // Switch from pass candidate to fail
        applyReset();
        applyStimulus(PASS_W, 2);
        applyStimulus(FAIL_W, 3);
        checkOutput("switch_no_fail", 0, SIG_FAIL, 32'd0);
        applyStimulus(FAIL_W, 1);
        checkOutput("switch_fail", 0, SIG_FAIL, 32'd1);
        checkOutput("switch_no_pass", 0, SIG_PASS, 32'd0);
        checkOutput("switch_vcyc", 0, SIG_VCYC, 32'd5);

        // Watchdog: the first edge changes 0 -> 1, so the 20th unchanged edge is edge 21
        applyReset();
        applyStimulus(32'd1, 20);
        checkOutput("tmo_not_yet", 1, SIG_TMO, 32'd0);
        applyStimulus(32'd1, 1);
        checkOutput("tmo_hit", 1, SIG_TMO, 32'd1);
        checkOutput("tmo_vcyc", 1, SIG_VCYC, 32'd20);
        checkOutput("a_no_watchdog", 0, SIG_BUSY, 32'd1);
        applyStimulus(32'd1, 7);
        checkOutput("tmo_finish", 1, SIG_FINISH, 32'd1);

        applyReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(32'd1, 10);
            applyStimulus(32'd2, 10);
        end
        checkOutput("toggle_no_tmo", 1, SIG_TMO, 32'd0);
        checkOutput("toggle_busy", 1, SIG_BUSY, 32'd1);

        // Reset three edges into drain, then a fresh pass
        applyReset();
        applyStimulus(PASS_W, 4);
        checkOutput("pre_drain_pass", 0, SIG_PASS, 32'd1);
        applyStimulus(PASS_W, 3);
        applyReset();
        checkOutput("mid_drain_pass_clr", 0, SIG_PASS, 32'd0);
        checkOutput("mid_drain_busy", 0, SIG_BUSY, 32'd1);
        checkOutput("mid_drain_vcyc", 0, SIG_VCYC, 32'd0);
        applyStimulus(PASS_W, 4);
        checkOutput("after_reset_pass", 0, SIG_PASS, 32'd1);
        checkOutput("after_reset_vcyc", 0, SIG_VCYC, 32'd3);

        // Reset on the same edge as the would-be verdict
        applyReset();
        applyStimulus(PASS_W, 3);
        applyReset();
        checkOutput("reset_beats_verdict", 0, SIG_PASS, 32'd0);
        applyStimulus(32'd0, 2);

        repeat (2) @(negedge clk_sys);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
